// File: rtl/loader_pkg.sv
// ============================================================================
// Module : loader_pkg
// Brief  : Shared state encoding and default widths for program_loader.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package loader_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    WRITE = 2'd1,
    RUN   = 2'd2
  } loader_state_t;

  localparam int DEFAULT_ADDR_W = 8;
  localparam int DEFAULT_DATA_W = 16;

endpackage

`default_nettype wire

// File: rtl/key_debounce.sv
// ============================================================================
// Module : key_debounce
// Brief  : Two-flop synchroniser plus stability counter for one raw active-low
//          key; emits a single-cycle pulse on each debounced press.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic CLK,
  input  logic Reset,
  input  logic key_n,
  output logic level,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // cnt tracks how many consecutive synchronised samples disagree with level
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      press <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync2;
        press <= ~sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/program_loader.sv
// ============================================================================
// Module : program_loader
// Brief  : Loads switch words into processor memory under key control and
//          holds the processor in reset until released to run.
//          Optional running checksum when LOADER_CHECKSUM_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W          = DEFAULT_ADDR_W,
  parameter int DATA_W          = DEFAULT_DATA_W,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [DATA_W-1:0] sw_data,
  input  logic              key_addr_n,
  input  logic              key_load_n,
  input  logic              key_run_n,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] next_addr,
  output logic              hold_proc,
  output logic              busy,
  output logic [ADDR_W:0]   words_loaded,
  output logic [DATA_W-1:0] checksum
);

  localparam int KEY_ADDR = 0;
  localparam int KEY_LOAD = 1;
  localparam int KEY_RUN  = 2;

  logic [2:0]    keys_n;
  logic [2:0]    press;
  logic [2:0]    key_level_unused;
  loader_state_t state;
  logic          accept;

  assign keys_n = {key_run_n, key_load_n, key_addr_n};
  assign accept = (state == WRITE) && wr_ready;

  generate
    for (genvar k = 0; k < 3; k++) begin : g_key
      key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_key_debounce (
        .CLK   (CLK),
        .Reset (Reset),
        .key_n (keys_n[k]),
        .level (key_level_unused[k]),
        .press (press[k])
      );
    end
  endgenerate

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state        <= LOAD;
      wr_valid     <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      next_addr    <= '0;
      hold_proc    <= 1'b1;
      busy         <= 1'b0;
      words_loaded <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (press[KEY_LOAD]) begin
            wr_addr  <= next_addr;
            wr_data  <= sw_data;
            wr_valid <= 1'b1;
            busy     <= 1'b1;
            state    <= WRITE;
          end else if (press[KEY_ADDR]) begin
            next_addr <= sw_data[ADDR_W-1:0];
          end else if (press[KEY_RUN]) begin
            hold_proc <= 1'b0;
            state     <= RUN;
          end
        end
        // Key pulses are deliberately dropped here; the request stays put
        // until memory accepts it.
        WRITE: begin
          if (wr_ready) begin
            wr_valid  <= 1'b0;
            busy      <= 1'b0;
            next_addr <= next_addr + 1'b1;
            if (!words_loaded[ADDR_W]) begin
              words_loaded <= words_loaded + 1'b1;
            end
            state <= LOAD;
          end
        end
        RUN: begin
          if (press[KEY_RUN]) begin
            hold_proc <= 1'b1;
            state     <= LOAD;
          end
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      sum <= '0;
    end else if (accept) begin
      sum <= sum + wr_data;
    end
  end

  assign checksum = sum;
`else
  logic accept_unused;

  assign accept_unused = accept;
  assign checksum      = '0;
`endif

endmodule

`default_nettype wire
